engine_rpm_model: RTL and testbench

Tick-based engine model that turns the driver's throttle, brake and gear-shift inputs into a 14-bit engine rpm value, a current gear number and a rev-limiter flag. Its `rpm` output feeds the rpm-driven piezo engine-sound stage and the LCD dashboard. It updates at a fixed rate derived from the system clock, and it enforces idle/maximum bounds, a rev limiter and a timed shift (clutch) interval with a small state machine.

---
 rtl/engine_rpm_model_if.sv | 31 +++
 rtl/engine_rpm_model.sv | 238 +++++++++++++++++++++++
 tb/tb_engine_rpm_model.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/engine_rpm_model_if.sv
// engine_rpm_model_if
// Bundles the driver controls and the engine-model outputs.
//   master : driver side, drives throttle/brake/shift pulses, reads engine state
//   slave  : engine model side, reads the controls, drives rpm/gear/limiter/tick
// Signals:
//   throttle, brake        : level controls, synchronous, already debounced
//   shift_up, shift_down   : one-cycle shift request pulses
//   rpm[13:0]              : engine rpm, registered
//   gear[2:0]              : current gear 1..5, registered
//   limiter                : high while the rev limiter holds fuel cut
//   tick                   : one-cycle strobe in the cycle before rpm updates
interface engine_rpm_model_if;
    logic        throttle;
    logic        brake;
    logic        shift_up;
    logic        shift_down;
    logic [13:0] rpm;
    logic [2:0]  gear;
    logic        limiter;
    logic        tick;

    modport master (
        output throttle, brake, shift_up, shift_down,
        input  rpm, gear, limiter, tick
    );

    modport slave (
        input  throttle, brake, shift_up, shift_down,
        output rpm, gear, limiter, tick
    );
endinterface

// File: rtl/engine_rpm_model.sv
// engine_rpm_model
// Tick-based engine model: converts throttle, brake and shift requests into
// an rpm value, a gear number and a rev-limiter flag, updated once per
// TICK_DIV = INPUT_FREQ / UPDATE_HZ clock cycles.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : engine_rpm_model_if.slave (controls in, rpm/gear/limiter/tick out)
module engine_rpm_model #(
    parameter int INPUT_FREQ  = 50_000_000,
    parameter int UPDATE_HZ   = 100,
    parameter int RPM_IDLE    = 800,
    parameter int RPM_MAX     = 8000,
    parameter int ACCEL_STEP  = 160,
    parameter int DECAY_STEP  = 40,
    parameter int BRAKE_STEP  = 150,
    parameter int SHIFT_DROP  = 1500,
    parameter int SHIFT_TICKS = 5,
    parameter int LIMIT_DROP  = 1000,
    parameter int LIMIT_TICKS = 3
) (
    input logic               clk,
    input logic               rst,
    engine_rpm_model_if.slave bus
);

    localparam int TICK_DIV = INPUT_FREQ / UPDATE_HZ;
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_MAX = (SHIFT_TICKS > LIMIT_TICKS) ? SHIFT_TICKS : LIMIT_TICKS;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] SHIFT_LAST = HOLD_W'(SHIFT_TICKS - 1);
    localparam logic [HOLD_W-1:0] LIMIT_LAST = HOLD_W'(LIMIT_TICKS);

    // 16-bit working copies so sums and differences never wrap before clamping
    localparam logic [15:0] IDLE_W  = 16'(RPM_IDLE);
    localparam logic [15:0] MAX_W   = 16'(RPM_MAX);
    localparam logic [15:0] ACCEL_W = 16'(ACCEL_STEP);
    localparam logic [15:0] DECAY_W = 16'(DECAY_STEP);
    localparam logic [15:0] BRAKE_W = 16'(BRAKE_STEP);
    localparam logic [15:0] SDROP_W = 16'(SHIFT_DROP);

    localparam logic [13:0] IDLE_14  = 14'(RPM_IDLE);
    localparam logic [13:0] MAX_14   = 14'(RPM_MAX);
    localparam logic [13:0] LIMIT_14 = 14'(RPM_MAX - LIMIT_DROP);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LIMIT = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    state_t             run_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               tick_r;
    logic               pend_up_r;
    logic               pend_dn_r;
    logic               pend_up_s;
    logic               pend_dn_s;
    logic               do_up_s;
    logic               do_dn_s;
    logic [13:0]        rpm_r;
    logic [13:0]        rpm_next_s;
    logic [13:0]        run_rpm_s;
    logic [15:0]        rpm_ext_s;
    logic [15:0]        accel_s;
    logic [15:0]        thr_sum_s;
    logic [2:0]         gear_r;
    logic [2:0]         gear_next_s;
    logic [2:0]         run_gear_s;
    logic [HOLD_W-1:0]  hold_r;
    logic [HOLD_W-1:0]  hold_next_s;
    logic               limiter_r;

    // a - b, never below idle
    function automatic logic [13:0] floor_sub(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] res;
        if (a < (b + IDLE_W)) begin
            res = IDLE_W;
        end else begin
            res = a - b;
        end
        return res[13:0];
    endfunction

    // a + b, never above the rev limit
    function automatic logic [13:0] cap_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] res;
        res = a + b;
        if (res > MAX_W) begin
            res = MAX_W;
        end else begin
            res = res;
        end
        return res[13:0];
    endfunction

    assign bus.rpm     = rpm_r;
    assign bus.gear    = gear_r;
    assign bus.limiter = limiter_r;
    assign bus.tick    = tick_r;

    // Divider advance and shift-request merge (a pulse in the tick cycle counts)
    always_comb begin
        cnt_next_s = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_LAST) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
        pend_up_s = pend_up_r | bus.shift_up;
        pend_dn_s = pend_dn_r | bus.shift_down;
        // opposing requests in one interval cancel each other
        do_up_s   = pend_up_s & ~pend_dn_s;
        do_dn_s   = pend_dn_s & ~pend_up_s;
    end

    // RUN-state rule chain; also used on the tick that leaves LIMIT
    always_comb begin
        rpm_ext_s   = {2'b00, rpm_r};
        accel_s     = ACCEL_W >> (gear_r - 3'd1);
        thr_sum_s   = rpm_ext_s + accel_s;
        run_rpm_s   = rpm_r;
        run_gear_s  = gear_r;
        run_state_s = ST_RUN;
        if (do_up_s && (gear_r < 3'd5)) begin
            run_gear_s  = gear_r + 3'd1;
            run_rpm_s   = floor_sub(rpm_ext_s, SDROP_W);
            run_state_s = ST_SHIFT;
        end else if (do_dn_s && (gear_r > 3'd1)) begin
            run_gear_s  = gear_r - 3'd1;
            run_rpm_s   = cap_add(rpm_ext_s, SDROP_W);
            run_state_s = ST_SHIFT;
        end else if (bus.brake) begin
            run_rpm_s = floor_sub(rpm_ext_s, BRAKE_W);
        end else if (bus.throttle) begin
            if (thr_sum_s >= MAX_W) begin
                run_rpm_s   = MAX_14;
                run_state_s = ST_LIMIT;
            end else begin
                run_rpm_s = thr_sum_s[13:0];
            end
        end else begin
            run_rpm_s = floor_sub(rpm_ext_s, DECAY_W);
        end
    end

    // FSM next state and rpm/gear/hold updates, only on tick
    always_comb begin
        state_next_s = state_r;
        rpm_next_s   = rpm_r;
        gear_next_s  = gear_r;
        hold_next_s  = hold_r;
        if (tick_r) begin
            case (state_r)
                ST_RUN: begin
                    state_next_s = run_state_s;
                    rpm_next_s   = run_rpm_s;
                    gear_next_s  = run_gear_s;
                    hold_next_s  = {HOLD_W{1'b0}};
                end
                ST_SHIFT: begin
                    rpm_next_s = floor_sub(rpm_ext_s, DECAY_W);
                    if (hold_r == SHIFT_LAST) begin
                        state_next_s = ST_RUN;
                        hold_next_s  = {HOLD_W{1'b0}};
                    end else begin
                        hold_next_s = hold_r + HOLD_W'(1);
                    end
                end
                ST_LIMIT: begin
                    // entry tick showed RPM_MAX; then LIMIT_TICKS ticks of fuel cut,
                    // and the following tick is evaluated as a normal RUN tick
                    if (hold_r == LIMIT_LAST) begin
                        state_next_s = run_state_s;
                        rpm_next_s   = run_rpm_s;
                        gear_next_s  = run_gear_s;
                        hold_next_s  = {HOLD_W{1'b0}};
                    end else begin
                        rpm_next_s  = LIMIT_14;
                        hold_next_s = hold_r + HOLD_W'(1);
                    end
                end
                default: begin
                    state_next_s = ST_RUN;
                    rpm_next_s   = IDLE_14;
                    gear_next_s  = 3'd1;
                    hold_next_s  = {HOLD_W{1'b0}};
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Tick divider, shift latches and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            tick_r    <= 1'b0;
            pend_up_r <= 1'b0;
            pend_dn_r <= 1'b0;
            rpm_r     <= IDLE_14;
            gear_r    <= 3'd1;
            hold_r    <= {HOLD_W{1'b0}};
            limiter_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            // registered strobe, high while the counter sits at TICK_DIV-1
            tick_r <= (cnt_next_s == CNT_LAST);
            if (tick_r) begin
                pend_up_r <= 1'b0;
                pend_dn_r <= 1'b0;
            end else begin
                pend_up_r <= pend_up_s;
                pend_dn_r <= pend_dn_s;
            end
            rpm_r     <= rpm_next_s;
            gear_r    <= gear_next_s;
            hold_r    <= hold_next_s;
            limiter_r <= (state_next_s == ST_LIMIT);
        end
    end

endmodule

// File: tb/tb_engine_rpm_model.sv
// tb_engine_rpm_model
// Directed bench for engine_rpm_model with TICK_DIV = 10 (main instance) and
// TICK_DIV = 25 (divider instance). Each step drives controls, pushes the
// reference-model result into a queue and pops it after the update edge.
module tb_engine_rpm_model;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    engine_rpm_model_if bus ();
    engine_rpm_model_if bus2 ();

    engine_rpm_model #(.INPUT_FREQ(1000), .UPDATE_HZ(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    engine_rpm_model #(.INPUT_FREQ(2500), .UPDATE_HZ(100)) dut_div (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        int rpm;
        int gear;
        bit lim;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state: mode 0 run, 1 shift, 2 limit
    int m_rpm;
    int m_gear;
    int m_mode;
    int m_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rpm  = 800;
        m_gear = 1;
        m_mode = 0;
        m_hold = 0;
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_tick(input bit thr, input bit brk, input bit su, input bit sd);
        bit   run_rules;
        exp_t e;
        run_rules = 1'b0;
        if (m_mode == 1) begin
            m_rpm = imax(800, m_rpm - 40);
            m_hold++;
            if (m_hold == 5) m_mode = 0;
        end else if (m_mode == 2 && m_hold < 3) begin
            m_rpm = 7000;
            m_hold++;
        end else begin
            run_rules = 1'b1;
        end
        if (run_rules) begin
            m_mode = 0;
            m_hold = 0;
            if (su && !sd && m_gear < 5) begin
                m_gear++;
                m_rpm  = imax(800, m_rpm - 1500);
                m_mode = 1;
            end else if (sd && !su && m_gear > 1) begin
                m_gear--;
                m_rpm  = imin(8000, m_rpm + 1500);
                m_mode = 1;
            end else if (brk) begin
                m_rpm = imax(800, m_rpm - 150);
            end else if (thr) begin
                m_rpm = m_rpm + (160 >> (m_gear - 1));
                if (m_rpm >= 8000) begin
                    m_rpm  = 8000;
                    m_mode = 2;
                end
            end else begin
                m_rpm = imax(800, m_rpm - 40);
            end
        end
        e.rpm  = m_rpm;
        e.gear = m_gear;
        e.lim  = (m_mode == 2);
        sb_q.push_back(e);
    endtask

    // Called at a negedge right after an update edge (divider at 0).
    task automatic step(input bit thr, input bit brk, input bit su, input bit sd, input bit glitch);
        int   n;
        exp_t e;
        n = 0;
        bus.throttle = thr;
        bus.brake    = brk;
        if (glitch) begin
            bus.throttle = ~thr;
            @(negedge clk); n++;
            bus.throttle = thr;
        end
        if (su) begin
            bus.shift_up = 1'b1;
            @(negedge clk); n++;
            bus.shift_up = 1'b0;
        end
        if (sd) begin
            bus.shift_down = 1'b1;
            @(negedge clk); n++;
            bus.shift_down = 1'b0;
        end
        model_tick(thr, brk, su, sd);
        while (bus.tick !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        check("tick_period", n, 9);
        @(negedge clk);
        e = sb_q.pop_front();
        check("rpm", bus.rpm, e.rpm);
        check("gear", bus.gear, e.gear);
        check("limiter", bus.limiter, e.lim);
        check("tick_one_cycle", bus.tick, 0);
    endtask

    initial begin
        int n;
        int k;
        bus.throttle    = 1'b0;
        bus.brake       = 1'b0;
        bus.shift_up    = 1'b0;
        bus.shift_down  = 1'b0;
        bus2.throttle   = 1'b0;
        bus2.brake      = 1'b0;
        bus2.shift_up   = 1'b0;
        bus2.shift_down = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rpm", bus.rpm, 800);
        check("rst_gear", bus.gear, 1);
        check("rst_limiter", bus.limiter, 0);
        check("rst_tick", bus.tick, 0);
        rst = 1'b0;
        model_reset();

        // idle, plus a throttle glitch between ticks
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_rpm", bus.rpm, 800);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("glitch_ignored", bus.rpm, 800);

        // gear-1 acceleration into the rev limiter
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("accel_1", bus.rpm, 960);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("accel_2", bus.rpm, 1120);
        repeat (42) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_limit", bus.rpm, 7840);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("limit_rpm", bus.rpm, 8000);
        check("limit_flag", bus.limiter, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("limit_cut", bus.rpm, 7000);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("limit_hold", bus.limiter, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("limit_exit_rpm", bus.rpm, 7160);
        check("limit_exit_flag", bus.limiter, 0);

        // brake overrides throttle, floored at idle
        repeat (45) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("brake_floor", bus.rpm, 800);

        // upshift, then a shift request during the clutch interval
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_shift", bus.rpm, 2400);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("shift_gear", bus.gear, 2);
        check("shift_rpm", bus.rpm, 900);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("shift_discard", bus.gear, 2);
        check("shift_decay", bus.rpm, 800);

        // opposing requests in one interval cancel
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("both_gear", bus.gear, 2);

        // climb gears; gear 3 gains 40 per tick; upshift at gear 5 ignored
        repeat (30) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("g3_base", bus.rpm, 1500);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("g3_accel", bus.rpm, 1540);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("g5_up_ignored", bus.gear, 5);
        check("g5_accel", bus.rpm, 810);

        // downshifts, climb above 6500 in gear 2, then downshift clamps
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("down_gear", bus.gear, 2);
        k = 0;
        while (m_rpm <= 6500 && k < 100) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            k++;
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("down_clamp", bus.rpm, 8000);
        check("down_clamp_gear", bus.gear, 1);
        check("down_no_limit", bus.limiter, 0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset asserted in a tick cycle takes effect without a clock edge
        n = 0;
        while (bus.tick !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        rst = 1'b1;
        #1;
        check("midrst_rpm", bus.rpm, 800);
        check("midrst_gear", bus.gear, 1);
        check("midrst_limiter", bus.limiter, 0);
        check("midrst_tick", bus.tick, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sb_q.delete();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_accel", bus.rpm, 960);

        // divider instance: first tick in cycle 24, then every 25 cycles
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            n = 0;
            do begin
                @(negedge clk); n++;
            end while (bus2.tick !== 1'b1 && n < 60);
            check("div_period", n, (t == 0) ? 24 : 25);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
